aes_key_expander: RTL and testbench
===================================

// Module: aes_key_expander
// PURPOSE
//  Sequential AES key-schedule engine; successor to the single-round combinational expander.
//  Supports AES-128/192/256 (Nk=4/6/8) and streams round keys 0..Nr to the cipher datapath.
//  Streaming uses a valid/ready handshake with backpressure.
//  Produces one 32-bit schedule word per cycle from a sliding window of the last Nk words.
//  Sits between key load (host/register file) and the round pipeline.
// PARAMETERS
//  MAX_NK   8  largest supported Nk (4, 6 or 8); sets window depth and key_in width
//  ROUND_W  4  width of rk_round
// PORTS
//  clk        in   1            single clock, rising edge
//  reset      in   1            synchronous, active-high
//  key_valid  in   1            key/mode offered
//  key_ready  out  1            high in IDLE only
//  key_in     in   32*MAX_NK    word 0 in MSBs; 128/192 modes use top 128/192 bits
//  mode       in   2            0=AES-128, 1=AES-192, 2=AES-256, 3=reserved
//  abort      in   1            terminate schedule, return to IDLE
//  rk_valid   out  1            rk_data holds a complete round key
//  rk_ready   in   1            consumer accepts rk_data when rk_valid && rk_ready
//  rk_data    out  128          round key, first schedule word in MSBs
//  rk_round   out  ROUND_W      round index of rk_data, 0..Nr
//  rk_last    out  1            rk_round == Nr
//  busy       out  1            state != IDLE
//  err        out  1            one-cycle pulse: rejected mode (3, or Nk > MAX_NK)
// BEHAVIOUR
//  Reset: IDLE; key_ready=1; rk_valid, busy, err, rk_last = 0; rk_data, rk_round = 0; rcon=8'h01; word index i=0.
//  States: IDLE -> (key_valid && key_ready, legal mode) RUN -> (round Nr key accepted) IDLE.
//  Illegal mode on accept: err=1 for one cycle; stay in IDLE; key is ignored.
//  RUN, word i (0..4*(Nr+1)-1), Nr = Nk+6:
//   - i < Nk: w = key word i.
//   - else temp = w[i-1]:
//     - i%Nk==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon = xtime(rcon), poly 8'h1b.
//     - Nk==8 && i%8==4: temp = SubWord(temp).
//     - w = w[i-Nk] ^ temp.
//  Each w shifts into the window and into a 3-word assembler.
//   - The 4th word loads {acc,w} into rk_data.
//   - Same cycle: rk_valid=1 and rk_round increments.
//  Stall rule: a 4th word is produced only if !rk_valid || rk_ready; otherwise the word index holds.
//   - Zero-bubble: accept and reload in the same cycle.
//  Latency: round 0 key valid 4 cycles after key accept; one key per 4 cycles without backpressure.
//  Totals: 44/52/60 words; rk_last=1 with round Nr; IDLE on its acceptance; key_ready re-asserts next cycle.
//  rk_data/rk_round stable while rk_valid && !rk_ready.
//  abort (any state, wins over all other events): next cycle IDLE, rk_valid=0, assembler/count/rcon cleared.
//   - key_valid in the abort cycle is ignored.
//  reset mid-run: identical to abort, plus outputs return to reset values.
// CONFIGURATION
//  KEYEXP_ZEROIZE_EN defined:
//   - On abort, reset, and acceptance of the last key, clear window, assembler and rk_data to 0 next cycle.
//   - No key material persists in IDLE.
//  Undefined: only control state clears; window/rk_data retain last values (rk_valid=0).
// STRUCTURE
//  aes_pkg holds:
//   - mode typedef (AES128/192/256)
//   - functions nk_of(mode) and nr_of(mode)
//   - xtime() function
//   - 256-entry S-box constant
//  Sub-module aes_sbox: combinational 8-bit S-box lookup from aes_pkg, instantiated 4x for SubWord.
// TESTING
//  AES-128 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, rk_ready=1:
//   -> 11 keys; round 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6; rk_last.
//  AES-192 key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b:
//   -> round 12 = e98ba06f_448c773c_8ecc7204_01002202.
//  AES-256 key 603deb10_..._0914dff4:
//   -> round 14 = fe4890d1_e6188d0b_046df344_706c631e.
//   -> rk_ready toggled randomly: same key sequence; rk_data stable while stalled.
//  mode=3 with key_valid -> err pulse 1 cycle; key_ready stays 1; no rk_valid.
//  abort in cycle 9 of AES-128 run -> next cycle IDLE, rk_valid=0.
//   -> Follow-up key produces the correct round-0 key.
//   -> With KEYEXP_ZEROIZE_EN: rk_data == 0.
//  reset asserted mid-stall (rk_valid=1, rk_ready=0) -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length modes, Nk/Nr helpers,
// GF(2^8) xtime and the forward S-box table.
package aes_pkg;

  typedef enum logic [1:0] {
    AES128   = 2'd0,
    AES192   = 2'd1,
    AES256   = 2'd2,
    AES_RSVD = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Byte x of the table sits at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [3:0] nk_of(input mode_t m);
    case (m)
      AES128:  nk_of = 4'd4;
      AES192:  nk_of = 4'd6;
      AES256:  nk_of = 4'd8;
      default: nk_of = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input mode_t m);
    return nk_of(m) + 4'd6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte per instance.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_lookup(a);

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule streaming round keys over valid/ready.
// Optional build macro KEYEXP_ZEROIZE_EN wipes all key material on abort, reset and completion.
module aes_key_expander #(
  parameter int MAX_NK  = 8,
  parameter int ROUND_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [32*MAX_NK-1:0] key_in,
  input  logic [1:0]           mode,
  input  logic                 abort,
  output logic                 rk_valid,
  input  logic                 rk_ready,
  output logic [127:0]         rk_data,
  output logic [ROUND_W-1:0]   rk_round,
  output logic                 rk_last,
  output logic                 busy,
  output logic                 err
);
  import aes_pkg::*;

  state_t                    state_q, state_d;
  mode_t                     mode_q, mode_d;
  logic [5:0]                i_q, i_d;
  logic [3:0]                mod_q, mod_d;
  logic [7:0]                rcon_q, rcon_d;
  logic [MAX_NK-1:0][31:0]   win_q, win_d;
  logic [95:0]               acc_q, acc_d;
  logic                      rk_valid_q, rk_valid_d;
  logic [127:0]              rk_data_q, rk_data_d;
  logic [ROUND_W-1:0]        rk_round_q, rk_round_d;
  logic                      rk_last_q, rk_last_d;
  logic                      err_q, err_d;

  logic [3:0]  nk, nr, nk_in;
  logic [5:0]  total;
  logic        i_ge_nk, last_word, consumed, produce, legal;
  logic [31:0] w_prev, w_old, sub_in, sub_out, temp, w_new;

  // Window index 0 holds w[i-1]; index nk-1 holds w[i-Nk]. The key is loaded
  // reversed so the first Nk cycles simply rotate the key words out.
  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
  end

  always_comb begin
    nk        = nk_of(mode_q);
    nr        = nr_of(mode_q);
    total     = {nr + 4'd1, 2'b00};
    nk_in     = nk_of(mode_t'(mode));
    legal     = (mode != 2'd3) && (int'(nk_in) <= MAX_NK);
    i_ge_nk   = (i_q >= {2'b00, nk});
    last_word = (i_q[1:0] == 2'd3);
    w_prev    = win_q[0];
    w_old     = '0;
    for (int k = 0; k < MAX_NK; k++)
      if (k == int'(nk) - 1) w_old = win_q[k];
    sub_in = (mod_q == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    if (!i_ge_nk)                           temp = '0;
    else if (mod_q == 4'd0)                 temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk == 4'd8 && mod_q == 4'd4)   temp = sub_out;
    else                                    temp = w_prev;
    w_new    = w_old ^ temp;
    consumed = rk_valid_q && rk_ready;
    produce  = (state_q == ST_RUN) && (i_q < total) && (!last_word || !rk_valid_q || rk_ready);

    state_d    = state_q;
    mode_d     = mode_q;
    i_d        = i_q;
    mod_d      = mod_q;
    rcon_d     = rcon_q;
    win_d      = win_q;
    acc_d      = acc_q;
    rk_valid_d = rk_valid_q && !consumed;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    rk_last_d  = rk_last_q;
    err_d      = 1'b0;

    if (state_q == ST_IDLE) begin
      if (key_valid && legal) begin
        state_d = ST_RUN;
        mode_d  = mode_t'(mode);
        i_d     = '0;
        mod_d   = '0;
        rcon_d  = 8'h01;
        acc_d   = '0;
        win_d   = '0;
        for (int k = 0; k < MAX_NK; k++)
          for (int j = 0; j < MAX_NK; j++)
            if (j == int'(nk_in) - 1 - k) win_d[k] = key_in[32*(MAX_NK-j)-1 -: 32];
      end else if (key_valid) begin
        err_d = 1'b1;
      end
    end else begin
      if (produce) begin
        win_d = {win_q[MAX_NK-2:0], w_new};
        i_d   = i_q + 6'd1;
        mod_d = (mod_q == nk - 4'd1) ? 4'd0 : mod_q + 4'd1;
        if (i_ge_nk && mod_q == 4'd0) rcon_d = xtime(rcon_q);
        if (last_word) begin
          rk_data_d  = {acc_q, w_new};
          rk_valid_d = 1'b1;
          rk_round_d = ROUND_W'(i_q[5:2]);
          rk_last_d  = (i_q[5:2] == nr);
        end else begin
          acc_d = {acc_q[63:0], w_new};
        end
      end
      if (consumed && rk_last_q) begin
        state_d   = ST_IDLE;
        i_d       = '0;
        mod_d     = '0;
        rcon_d    = 8'h01;
        rk_last_d = 1'b0;
`ifdef KEYEXP_ZEROIZE_EN
        win_d     = '0;
        acc_d     = '0;
        rk_data_d = '0;
`endif
      end
    end

    // abort overrides every other event, including a key offer in the same cycle
    if (abort) begin
      state_d    = ST_IDLE;
      i_d        = '0;
      mod_d      = '0;
      rcon_d     = 8'h01;
      acc_d      = '0;
      rk_valid_d = 1'b0;
      rk_last_d  = 1'b0;
      err_d      = 1'b0;
`ifdef KEYEXP_ZEROIZE_EN
      win_d      = '0;
      rk_data_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= AES128;
      i_q        <= '0;
      mod_q      <= '0;
      rcon_q     <= 8'h01;
      acc_q      <= '0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      rk_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      i_q        <= i_d;
      mod_q      <= mod_d;
      rcon_q     <= rcon_d;
      acc_q      <= acc_d;
      rk_valid_q <= rk_valid_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      rk_last_q  <= rk_last_d;
      err_q      <= err_d;
    end
  end

`ifdef KEYEXP_ZEROIZE_EN
  always_ff @(posedge clk) begin
    if (reset) win_q <= '0;
    else       win_q <= win_d;
  end
`else
  always_ff @(posedge clk) begin
    win_q <= win_d;
  end
`endif

  assign key_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rk_valid  = rk_valid_q;
  assign rk_data   = rk_data_q;
  assign rk_round  = rk_round_q;
  assign rk_last   = rk_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: FIPS-197 vectors, random keys and
// backpressure, illegal mode, abort and reset during a stall.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         reset, key_valid, key_ready, abort;
  logic         rk_valid, rk_last, busy, err;
  logic         rk_ready = 1'b0;
  logic [255:0] key_in;
  logic [1:0]   mode;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;

  always #5 clk = ~clk;

  aes_key_expander #(.MAX_NK(8), .ROUND_W(4)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .mode(mode), .abort(abort), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_data(rk_data), .rk_round(rk_round),
    .rk_last(rk_last), .busy(busy), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model: S-box derived from GF(2^8) inversion plus affine map,
  // full schedule computed into an array of words.
  logic [7:0]  m_sbox [256];
  logic [31:0] mw [60];

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   round;
    logic         last;
  } rk_t;
  rk_t exp_q [$];
  rk_t e;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a = a_in;
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
  endfunction

  function automatic void model_expand(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    rk_t         r;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) mw[i] = key[255-32*i -: 32];
      else begin
        t = mw[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk == 8 && i % 8 == 4) begin
          t = subw(t);
        end
        mw[i] = mw[i-nk] ^ t;
      end
    end
    for (int k = 0; k <= nk + 6; k++) begin
      r.data  = {mw[4*k], mw[4*k+1], mw[4*k+2], mw[4*k+3]};
      r.round = 4'(k);
      r.last  = (k == nk + 6);
      exp_q.push_back(r);
    end
  endfunction

  // Consumer-side ready: 0 = always ready, 1 = random, 2 = held low.
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       rk_ready = 1'b1;
      1:       rk_ready = 1'($urandom_range(0, 1));
      default: rk_ready = 1'b0;
    endcase
  end

  // Compare process: every accepted key against the model, stability under stall.
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data  = '0;
  logic [3:0]   prev_round = '0;
  logic [127:0] last_rx    = '0;
  int           n_rx       = 0;

  always @(negedge clk) begin
    if (reset === 1'b0) check("ready_vs_busy", key_ready, !busy);
    if (prev_stall) begin
      check("stall_valid", rk_valid, 1'b1);
      check("stall_data", rk_data, prev_data);
      check("stall_round", rk_round, prev_round);
    end
    if (rk_valid && rk_ready && !reset && !abort) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rk: got round %0d expected none", rk_round);
      end else begin
        e = exp_q.pop_front();
        check("rk_data", rk_data, e.data);
        check("rk_round", rk_round, e.round);
        check("rk_last", rk_last, e.last);
      end
      last_rx = rk_data;
      n_rx++;
    end
    prev_stall = rk_valid && !rk_ready && !reset && !abort;
    prev_data  = rk_data;
    prev_round = rk_round;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_key(input logic [1:0] m, input logic [255:0] k);
    check("key_ready_idle", key_ready, 1'b1);
    model_expand(int'(m) * 2 + 4, k);
    mode      = m;
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key_in    = rand256();
  endtask

  task automatic run_key(input logic [1:0] m, input logic [255:0] k);
    int nk, cyc, rx0;
    nk  = int'(m) * 2 + 4;
    rx0 = n_rx;
    cyc = 0;
    start_key(m, k);
    for (int t = 0; t < 20; t++) begin
      tick();
      cyc++;
      if (rk_valid) break;
    end
    check("first_rk_latency", cyc, 4);
    for (int t = 0; t < 2000 && busy; t++) begin
      tick();
      cyc++;
    end
    check("run_done", busy, 1'b0);
    if (ready_mode == 0) check("run_cycles", cyc, 4*(nk+7)+1);
    check("rx_count", n_rx - rx0, nk + 7);
    check("queue_empty", exp_q.size(), 0);
    check("rk_valid_after", rk_valid, 1'b0);
  endtask

  logic [255:0] k128, k192, k256;
  logic         saw_valid;

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    abort     = 1'b0;
    mode      = 2'd0;
    key_in    = '0;
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    build_sbox();
    check("model_sbox_00", m_sbox[8'h00], 8'h63);
    check("model_sbox_53", m_sbox[8'h53], 8'hed);
    check("model_sbox_ff", m_sbox[8'hff], 8'h16);

    repeat (3) tick();
    check("rst_key_ready", key_ready, 1'b1);
    check("rst_rk_valid", rk_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rk_last", rk_last, 1'b0);
    check("rst_rk_data", rk_data, 128'h0);
    check("rst_rk_round", rk_round, 4'h0);
    reset = 1'b0;
    tick();

    // FIPS-197 vectors
    ready_mode = 0;
    tick();
    run_key(2'd0, k128);
    check("model_aes128_r10", {mw[40], mw[41], mw[42], mw[43]}, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("dut_aes128_r10", last_rx, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_key(2'd1, k192 | {192'h0, 64'(rand256())});
    check("model_aes192_r12", {mw[48], mw[49], mw[50], mw[51]}, 128'he98ba06f448c773c8ecc720401002202);
    check("dut_aes192_r12", last_rx, 128'he98ba06f448c773c8ecc720401002202);
    ready_mode = 1;
    tick();
    run_key(2'd2, k256);
    check("model_aes256_r14", {mw[56], mw[57], mw[58], mw[59]}, 128'hfe4890d1e6188d0b046df344706c631e);
    check("dut_aes256_r14", last_rx, 128'hfe4890d1e6188d0b046df344706c631e);

    // random keys and modes under random backpressure
    for (int it = 0; it < 6; it++) run_key(2'($urandom_range(0, 2)), rand256());

    // reserved mode is rejected
    ready_mode = 0;
    mode      = 2'd3;
    key_in    = rand256();
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("err_pulse", err, 1'b1);
    check("err_key_ready", key_ready, 1'b1);
    check("err_busy", busy, 1'b0);
    tick();
    check("err_clear", err, 1'b0);
    saw_valid = 1'b0;
    repeat (6) begin
      tick();
      saw_valid = saw_valid | rk_valid | busy;
    end
    check("err_no_rk", saw_valid, 1'b0);

    // abort in cycle 9 of an AES-128 run, with a key offered in the abort cycle
    start_key(2'd0, rand256());
    repeat (9) tick();
    abort     = 1'b1;
    key_valid = 1'b1;
    tick();
    abort     = 1'b0;
    key_valid = 1'b0;
    exp_q.delete();
    check("abort_busy", busy, 1'b0);
    check("abort_rk_valid", rk_valid, 1'b0);
    check("abort_key_ready", key_ready, 1'b1);
`ifdef KEYEXP_ZEROIZE_EN
    check("abort_zeroize", rk_data, 128'h0);
`endif
    tick();
    check("abort_key_ignored", busy, 1'b0);
    run_key(2'd0, rand256());

    // reset while a round key is stalled
    ready_mode = 2;
    tick();
    start_key(2'd2, rand256());
    saw_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (rk_valid) begin
        saw_valid = 1'b1;
        break;
      end
    end
    check("stall_reached", saw_valid, 1'b1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_key_ready", key_ready, 1'b1);
    check("mid_rst_rk_valid", rk_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_rk_last", rk_last, 1'b0);
    check("mid_rst_rk_round", rk_round, 4'h0);
    check("mid_rst_rk_data", rk_data, 128'h0);
    ready_mode = 0;
    tick();
    run_key(2'd1, rand256());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
